symbol_cmd_buffer: RTL and testbench

Parametrised per-symbol command store for the pong drawing pipeline. Sits between the packet parser, which delivers decoded command packets per the ICD, and the renderer, which reads symbol state by ID. It accepts program, move, delete and clear-all commands through a valid/ready handshake. Positions are double-buffered: move commands are staged and committed on a frame boundary, so the renderer never sees a half-updated frame.

---
 rtl/symbol_buf_pkg.sv | 31 +++
 rtl/symbol_cmd_buffer_if.sv | 35 +++
 rtl/symbol_slot_ram.sv | 36 +++
 rtl/symbol_cmd_buffer.sv | 198 +++++++++++++++++++
 tb/tb_symbol_cmd_buffer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/symbol_buf_pkg.sv
// Shared types for the symbol command buffer.
//   cmd_type_e  : command opcodes carried on cmd_type
//   pos_t       : one {y, x} position at the default coordinate width
//   state_e     : command FSM states
//   id_in_range : true when an 8-bit command ID addresses an existing slot
package symbol_buf_pkg;

    typedef enum logic [1:0] {
        CMD_PROG      = 2'd0,
        CMD_MOVE      = 2'd1,
        CMD_DELETE    = 2'd2,
        CMD_CLEAR_ALL = 2'd3
    } cmd_type_e;

    localparam int DEF_POS_BITS = 10;

    typedef struct packed {
        logic [DEF_POS_BITS-1:0] y;
        logic [DEF_POS_BITS-1:0] x;
    } pos_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic id_in_range(input logic [7:0] id, input int unsigned num_slots);
        return 32'(id) < num_slots;
    endfunction

endpackage

// File: rtl/symbol_cmd_buffer_if.sv
// Command and read bus of the symbol command buffer.
//   master : parser/renderer side (drives cmd_* and rd_en/rd_id)
//   slave  : the buffer (drives cmd_ready and the rd_* results)
interface symbol_cmd_buffer_if
    import symbol_buf_pkg::*;
#(
    parameter int NUM_SYMBOLS = 16,
    parameter int ATTR_BITS   = 24,
    parameter int POS_BITS    = 10
);
    localparam int SYM_ID_BITS = $clog2(NUM_SYMBOLS);

    logic                   cmd_valid;
    logic                   cmd_ready;
    cmd_type_e              cmd_type;
    logic [7:0]             cmd_sym_id;
    logic [ATTR_BITS-1:0]   cmd_data;

    logic                   rd_en;
    logic [SYM_ID_BITS-1:0] rd_id;
    logic                   rd_data_valid;
    logic                   rd_present;
    logic [ATTR_BITS-1:0]   rd_attr;
    logic [2*POS_BITS-1:0]  rd_pos;

    modport master (
        output cmd_valid, cmd_type, cmd_sym_id, cmd_data, rd_en, rd_id,
        input  cmd_ready, rd_data_valid, rd_present, rd_attr, rd_pos
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_sym_id, cmd_data, rd_en, rd_id,
        output cmd_ready, rd_data_valid, rd_present, rd_attr, rd_pos
    );
endinterface

// File: rtl/symbol_slot_ram.sv
// Per-slot attribute store: one write port, one registered read port.
// A same-cycle write and read of one address returns the old word.
//   clk, rst_n           : clock, asynchronous active-low reset
//   we, waddr, wdata     : write port
//   re, raddr, rdata     : read port, rdata updates one cycle after re
module symbol_slot_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 24,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array sits under the async reset because every slot must read
    // back as zero straight out of reset; that rules out mapping it to a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/symbol_cmd_buffer.sv
// Per-symbol command store for the pong drawing pipeline.
// Accepts PROG/MOVE/DELETE/CLEAR_ALL over a valid/ready handshake; MOVE
// positions are staged and only become visible after a frame_commit pulse.
//   i_clk, n_btn_reset : clock, asynchronous active-low reset
//   bus (slave)        : command handshake and renderer read port
//   frame_commit       : frame-boundary pulse, copies pending -> committed
//   present_mask       : bitmap of programmed slots
//   err_id_range       : sticky, a command named a non-existent slot
//   err_unprog         : sticky, MOVE/DELETE named an unprogrammed slot
module symbol_cmd_buffer
    import symbol_buf_pkg::*;
#(
    parameter  int NUM_SYMBOLS = 16,
    parameter  int ATTR_BITS   = 24,
    parameter  int POS_BITS    = 10,
    localparam int SYM_ID_BITS = $clog2(NUM_SYMBOLS)
) (
    input  logic                   i_clk,
    input  logic                   n_btn_reset,
    symbol_cmd_buffer_if.slave     bus,
    input  logic                   frame_commit,
    output logic [NUM_SYMBOLS-1:0] present_mask,
    output logic                   err_id_range,
    output logic                   err_unprog
);
    localparam int POS_W = 2 * POS_BITS;
    localparam logic [SYM_ID_BITS-1:0] LAST_IDX = SYM_ID_BITS'(NUM_SYMBOLS - 1);

    logic [NUM_SYMBOLS-1:0] present_q, present_d;
    logic [POS_W-1:0]       pending_q [NUM_SYMBOLS];
    logic [POS_W-1:0]       pending_d [NUM_SYMBOLS];
    logic [POS_W-1:0]       pos_q     [NUM_SYMBOLS];
    logic [POS_W-1:0]       pos_d     [NUM_SYMBOLS];
    logic                   err_id_range_q, err_id_range_d;
    logic                   err_unprog_q, err_unprog_d;

    state_e                 state_q;
    logic [SYM_ID_BITS-1:0] clr_idx_q;
    logic                   cmd_ready_q;

    logic                   rd_data_valid_q, rd_present_q;
    logic [POS_W-1:0]       rd_pos_q;

    logic                   ram_we;
    logic [SYM_ID_BITS-1:0] ram_waddr;
    logic [ATTR_BITS-1:0]   ram_wdata;

    logic                   cmd_fire;
    logic                   id_ok;
    logic [SYM_ID_BITS-1:0] cmd_idx;

    assign cmd_fire = bus.cmd_valid && cmd_ready_q;
    assign id_ok    = id_in_range(bus.cmd_sym_id, NUM_SYMBOLS);
    assign cmd_idx  = bus.cmd_sym_id[SYM_ID_BITS-1:0];

    // NOTE: every output of this block gets a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    always_comb begin
        present_d      = present_q;
        pending_d      = pending_q;
        pos_d          = pos_q;
        err_id_range_d = err_id_range_q;
        err_unprog_d   = err_unprog_q;
        ram_we         = 1'b0;
        ram_waddr      = cmd_idx;
        ram_wdata      = bus.cmd_data;

        if (state_q == ST_CLEAR) begin
            present_d[clr_idx_q] = 1'b0;
            pending_d[clr_idx_q] = '0;
            pos_d[clr_idx_q]     = '0;
            ram_we               = 1'b1;
            ram_waddr            = clr_idx_q;
            ram_wdata            = '0;
        end else begin
            // Commit first from pre-cycle state; a same-cycle command then
            // overrides its own slot, so a MOVE waits for the next commit.
            if (frame_commit) begin
                for (int i = 0; i < NUM_SYMBOLS; i++) begin
                    if (present_q[i]) pos_d[i] = pending_q[i];
                end
            end

            if (cmd_fire) begin
                unique case (bus.cmd_type)
                    CMD_PROG: begin
                        if (!id_ok) begin
                            err_id_range_d = 1'b1;
                        end else begin
                            ram_we             = 1'b1;
                            present_d[cmd_idx] = 1'b1;
                            pending_d[cmd_idx] = '0;
                            pos_d[cmd_idx]     = '0;
                        end
                    end
                    CMD_MOVE: begin
                        if (!id_ok)                  err_id_range_d = 1'b1;
                        else if (!present_q[cmd_idx]) err_unprog_d   = 1'b1;
                        else pending_d[cmd_idx] = bus.cmd_data[POS_W-1:0];
                    end
                    CMD_DELETE: begin
                        if (!id_ok)                  err_id_range_d = 1'b1;
                        else if (!present_q[cmd_idx]) err_unprog_d   = 1'b1;
                        else present_d[cmd_idx] = 1'b0;
                    end
                    CMD_CLEAR_ALL: ;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge n_btn_reset) begin
        if (!n_btn_reset) begin
            present_q      <= '0;
            err_id_range_q <= 1'b0;
            err_unprog_q   <= 1'b0;
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                pending_q[i] <= '0;
                pos_q[i]     <= '0;
            end
        end else begin
            present_q      <= present_d;
            pending_q      <= pending_d;
            pos_q          <= pos_d;
            err_id_range_q <= err_id_range_d;
            err_unprog_q   <= err_unprog_d;
        end
    end

    // Command FSM; cmd_ready is a registered output that drops for the
    // whole sweep, one slot cleared per cycle.
    always_ff @(posedge i_clk or negedge n_btn_reset) begin
        if (!n_btn_reset) begin
            state_q     <= ST_IDLE;
            clr_idx_q   <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire && bus.cmd_type == CMD_CLEAR_ALL) begin
                        state_q     <= ST_CLEAR;
                        clr_idx_q   <= '0;
                        cmd_ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + SYM_ID_BITS'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read port: samples state before this edge's writes land.
    always_ff @(posedge i_clk or negedge n_btn_reset) begin
        if (!n_btn_reset) begin
            rd_data_valid_q <= 1'b0;
            rd_present_q    <= 1'b0;
            rd_pos_q        <= '0;
        end else begin
            rd_data_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_present_q <= present_q[bus.rd_id];
                rd_pos_q     <= pos_q[bus.rd_id];
            end
        end
    end

    symbol_slot_ram #(
        .DEPTH (NUM_SYMBOLS),
        .WIDTH (ATTR_BITS)
    ) u_attr_ram (
        .clk   (i_clk),
        .rst_n (n_btn_reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (bus.rd_en),
        .raddr (bus.rd_id),
        .rdata (bus.rd_attr)
    );

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_present    = rd_present_q;
    assign bus.rd_pos        = rd_pos_q;
    assign present_mask      = present_q;
    assign err_id_range      = err_id_range_q;
    assign err_unprog        = err_unprog_q;
endmodule

// File: tb/tb_symbol_cmd_buffer.sv
// Self-checking bench for symbol_cmd_buffer (16 slots, 24-bit attr, 10-bit coords).
module tb_symbol_cmd_buffer;
    import symbol_buf_pkg::*;

    localparam int N  = 16;
    localparam int AB = 24;
    localparam int PB = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_commit = 1'b0;
    logic [N-1:0]  present_mask;
    logic          err_id_range, err_unprog;

    int total = 0;
    int bad   = 0;

    symbol_cmd_buffer_if #(.NUM_SYMBOLS(N), .ATTR_BITS(AB), .POS_BITS(PB)) bus ();

    symbol_cmd_buffer #(.NUM_SYMBOLS(N), .ATTR_BITS(AB), .POS_BITS(PB)) dut (
        .i_clk        (clk),
        .n_btn_reset  (rst_n),
        .bus          (bus),
        .frame_commit (frame_commit),
        .present_mask (present_mask),
        .err_id_range (err_id_range),
        .err_unprog   (err_unprog)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*PB-1:0] mkpos(input int y, input int x);
        pos_t p;
        p.y = PB'(y);
        p.x = PB'(x);
        return p;
    endfunction

    // ---------------- reference model ----------------
    bit               m_present [N];
    logic [AB-1:0]    m_attr    [N];
    logic [2*PB-1:0]  m_pend    [N];
    logic [2*PB-1:0]  m_pos     [N];
    bit               m_err_id, m_err_unprog;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_present[i] = 0; m_attr[i] = '0; m_pend[i] = '0; m_pos[i] = '0;
        end
        m_err_id = 0; m_err_unprog = 0;
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = m_present[i];
        return m;
    endfunction

    // One accepted cycle: the commit sees the old pending values, then the command applies.
    task automatic model_cycle(input bit commit, input bit has_cmd, input cmd_type_e t,
                               input int id, input logic [AB-1:0] d);
        if (commit)
            for (int i = 0; i < N; i++) if (m_present[i]) m_pos[i] = m_pend[i];
        if (has_cmd) begin
            if (t == CMD_CLEAR_ALL) begin
                for (int i = 0; i < N; i++) begin
                    m_present[i] = 0; m_attr[i] = '0; m_pend[i] = '0; m_pos[i] = '0;
                end
            end else if (id >= N) begin
                m_err_id = 1;
            end else if (t == CMD_PROG) begin
                m_present[id] = 1; m_attr[id] = d; m_pend[id] = '0; m_pos[id] = '0;
            end else if (!m_present[id]) begin
                m_err_unprog = 1;
            end else if (t == CMD_MOVE) begin
                m_pend[id] = d[2*PB-1:0];
            end else begin
                m_present[id] = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_type = CMD_PROG; bus.cmd_sym_id = '0; bus.cmd_data = '0;
        bus.rd_en = 0; bus.rd_id = '0; frame_commit = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit has_cmd, input cmd_type_e t, input logic [7:0] id,
                        input logic [AB-1:0] d, input bit commit);
        int guard = 0;
        while (!bus.cmd_ready && guard < 64) begin @(negedge clk); guard++; end
        check("send_ready_timeout", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = has_cmd; bus.cmd_type = t; bus.cmd_sym_id = id; bus.cmd_data = d;
        frame_commit = commit;
        @(negedge clk);
        bus.cmd_valid = 0; frame_commit = 0;
    endtask

    task automatic read_check(input string tag, input int id, input bit e_pres,
                              input logic [AB-1:0] e_attr, input logic [2*PB-1:0] e_pos);
        bus.rd_en = 1; bus.rd_id = 4'(id);
        @(negedge clk);
        bus.rd_en = 0;
        check({tag, "_rdv"},  64'(bus.rd_data_valid), 64'd1);
        check({tag, "_pres"}, 64'(bus.rd_present), 64'(e_pres));
        check({tag, "_attr"}, 64'(bus.rd_attr), 64'(e_attr));
        check({tag, "_pos"},  64'(bus.rd_pos), 64'(e_pos));
    endtask

    task automatic prog_all();
        for (int i = 0; i < N; i++) begin
            bus.cmd_valid = 1; bus.cmd_type = CMD_PROG;
            bus.cmd_sym_id = 8'(i); bus.cmd_data = AB'(i * 24'h010101);
            @(negedge clk);
            check($sformatf("b2b_ready%0d", i), 64'(bus.cmd_ready), 64'd1);
        end
        bus.cmd_valid = 0;
        check("b2b_mask", 64'(present_mask), 64'hFFFF);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit               has_cmd;
        cmd_type_e        typ;
        logic [7:0]       id;
        logic [AB-1:0]    data;
        bit               commit;
        int               rd_id;
        logic [N-1:0]     e_mask;
        bit               e_err_id;
        bit               e_err_unprog;
        bit               e_present;
        logic [AB-1:0]    e_attr;
        logic [2*PB-1:0]  e_pos;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit hc, input cmd_type_e t, input int id, input logic [AB-1:0] d,
                                input bit cm, input int rid, input logic [N-1:0] mask,
                                input bit eid, input bit eun, input bit pr,
                                input logic [AB-1:0] at, input logic [2*PB-1:0] ps);
        vec_t v;
        v.has_cmd = hc; v.typ = t; v.id = 8'(id); v.data = d; v.commit = cm; v.rd_id = rid;
        v.e_mask = mask; v.e_err_id = eid; v.e_err_unprog = eun;
        v.e_present = pr; v.e_attr = at; v.e_pos = ps;
        return v;
    endfunction

    initial begin
        int low_cnt;
        int guard;

        idle_inputs();
        model_reset();

        // Table: hand-derived expected values.
        vecs.push_back(mk(1, CMD_PROG,   3, 24'hABCDEF, 0, 3, 16'h0008, 0, 0, 1, 24'hABCDEF, '0));
        vecs.push_back(mk(1, CMD_MOVE,   3, 24'(mkpos(5,7)), 0, 3, 16'h0008, 0, 0, 1, 24'hABCDEF, '0));
        vecs.push_back(mk(0, CMD_PROG,   0, '0, 1, 3, 16'h0008, 0, 0, 1, 24'hABCDEF, mkpos(5,7)));
        vecs.push_back(mk(1, CMD_MOVE,   3, 24'(mkpos(9,9)), 1, 3, 16'h0008, 0, 0, 1, 24'hABCDEF, mkpos(5,7)));
        vecs.push_back(mk(0, CMD_PROG,   0, '0, 1, 3, 16'h0008, 0, 0, 1, 24'hABCDEF, mkpos(9,9)));
        vecs.push_back(mk(1, CMD_MOVE,   4, 24'(mkpos(1,1)), 0, 4, 16'h0008, 0, 1, 0, '0, '0));
        vecs.push_back(mk(1, CMD_PROG,  20, 24'h777777, 0, 4, 16'h0008, 1, 1, 0, '0, '0));
        vecs.push_back(mk(1, CMD_PROG,   2, 24'h123456, 0, 2, 16'h000C, 1, 1, 1, 24'h123456, '0));
        vecs.push_back(mk(1, CMD_PROG,   6, 24'h654321, 0, 6, 16'h004C, 1, 1, 1, 24'h654321, '0));
        vecs.push_back(mk(1, CMD_MOVE,   2, 24'(mkpos(3,4)), 0, 2, 16'h004C, 1, 1, 1, 24'h123456, '0));
        vecs.push_back(mk(1, CMD_DELETE, 3, '0, 0, 3, 16'h0044, 1, 1, 0, 24'hABCDEF, mkpos(9,9)));
        vecs.push_back(mk(1, CMD_DELETE, 2, '0, 0, 2, 16'h0040, 1, 1, 0, 24'h123456, '0));
        vecs.push_back(mk(0, CMD_PROG,   0, '0, 1, 2, 16'h0040, 1, 1, 0, 24'h123456, '0));
        vecs.push_back(mk(1, CMD_DELETE, 2, '0, 0, 6, 16'h0040, 1, 1, 1, 24'h654321, '0));

        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_ready",   64'(bus.cmd_ready), 64'd1);
        check("rst_rdv",     64'(bus.rd_data_valid), 64'd0);
        check("rst_pres",    64'(bus.rd_present), 64'd0);
        check("rst_attr",    64'(bus.rd_attr), 64'd0);
        check("rst_pos",     64'(bus.rd_pos), 64'd0);
        check("rst_mask",    64'(present_mask), 64'd0);
        check("rst_err_id",  64'(err_id_range), 64'd0);
        check("rst_err_un",  64'(err_unprog), 64'd0);

        foreach (vecs[i]) begin
            send(vecs[i].has_cmd, vecs[i].typ, vecs[i].id, vecs[i].data, vecs[i].commit);
            check($sformatf("v%0d_mask", i),   64'(present_mask), 64'(vecs[i].e_mask));
            check($sformatf("v%0d_errid", i),  64'(err_id_range), 64'(vecs[i].e_err_id));
            check($sformatf("v%0d_errun", i),  64'(err_unprog),   64'(vecs[i].e_err_unprog));
            read_check($sformatf("v%0d", i), vecs[i].rd_id, vecs[i].e_present, vecs[i].e_attr, vecs[i].e_pos);
        end
        @(negedge clk);
        check("rdv_idle", 64'(bus.rd_data_valid), 64'd0);

        // Back-to-back programming, then CLEAR_ALL with a PROG held during the sweep.
        do_reset();
        prog_all();
        read_check("b2b_rd9", 9, 1, 24'h090909, '0);

        bus.cmd_valid = 1; bus.cmd_type = CMD_CLEAR_ALL; bus.cmd_sym_id = 8'hFF;
        @(negedge clk);
        bus.cmd_type = CMD_PROG; bus.cmd_sym_id = 8'd1; bus.cmd_data = 24'h111111;
        bus.rd_en = 1; bus.rd_id = 4'd5;
        low_cnt = 0; guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            low_cnt++; guard++;
            @(negedge clk);
        end
        check("clr_rdv_during", 64'(bus.rd_data_valid), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 0; bus.rd_en = 0;
        check("clr_low_cycles", 64'(low_cnt), 64'd16);
        check("clr_mask_after", 64'(present_mask), 64'h0002);
        read_check("clr_rd5", 5, 0, '0, '0);
        read_check("clr_rd1", 1, 1, 24'h111111, '0);

        // Reset during the sweep.
        prog_all();
        bus.cmd_valid = 1; bus.cmd_type = CMD_CLEAR_ALL;
        @(negedge clk);
        bus.cmd_valid = 0;
        repeat (4) @(negedge clk);
        check("sweep5_ready", 64'(bus.cmd_ready), 64'd0);
        check("sweep5_mask",  64'(present_mask), 64'hFFF0);
        rst_n = 0;
        @(negedge clk);
        check("sweep_rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("sweep_rst_mask",  64'(present_mask), 64'd0);
        rst_n = 1;
        @(negedge clk);
        check("sweep_rst_ready2", 64'(bus.cmd_ready), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            bit              rdy, do_cmd, cm, rd, chk_rd;
            cmd_type_e       t;
            int              id, rid, r;
            logic [AB-1:0]   d;
            bit              e_pres;
            logic [AB-1:0]   e_attr;
            logic [2*PB-1:0] e_pos;

            rdy    = bus.cmd_ready;
            do_cmd = rdy && ($urandom_range(0, 3) != 0);
            r      = $urandom_range(0, 31);
            t      = (r < 12) ? CMD_PROG : (r < 22) ? CMD_MOVE : (r < 30) ? CMD_DELETE : CMD_CLEAR_ALL;
            id     = $urandom_range(0, 19);
            d      = AB'($urandom);
            cm     = ($urandom_range(0, 3) == 0);
            rd     = ($urandom_range(0, 1) == 1);
            rid    = $urandom_range(0, N - 1);

            bus.cmd_valid = do_cmd; bus.cmd_type = t; bus.cmd_sym_id = 8'(id); bus.cmd_data = d;
            frame_commit = cm; bus.rd_en = rd; bus.rd_id = 4'(rid);

            chk_rd = rd && rdy;
            e_pres = m_present[rid]; e_attr = m_attr[rid]; e_pos = m_pos[rid];
            if (rdy) model_cycle(cm, do_cmd, t, id, d);

            @(negedge clk);
            check("rnd_rdv", 64'(bus.rd_data_valid), 64'(rd));
            if (chk_rd) begin
                check("rnd_pres", 64'(bus.rd_present), 64'(e_pres));
                check("rnd_attr", 64'(bus.rd_attr), 64'(e_attr));
                check("rnd_pos",  64'(bus.rd_pos), 64'(e_pos));
            end
            if (bus.cmd_ready) check("rnd_mask", 64'(present_mask), 64'(model_mask()));
            check("rnd_errid", 64'(err_id_range), 64'(m_err_id));
            check("rnd_errun", 64'(err_unprog), 64'(m_err_unprog));
        end
        idle_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
